// File: rtl/posit_stream_decoder_if.sv
// Stream bundle for the posit decoder: packed posit in, decoded fields out.
// Handshake: a word moves on a rising clock edge where valid and ready are both
// high; a producer holds valid and its payload stable until that edge, and
// valid never drops before its word is taken.
interface posit_stream_decoder_if #(
    parameter int WIDTH = 7
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_posit;
    logic             out_valid;
    logic             out_ready;
    logic             out_sign;
    logic [7:0]       out_regime;
    logic [7:0]       out_exponent;
    logic [7:0]       out_mantissa;
    logic             out_zero;
    logic             out_nar;

    // Decoder side.
    modport slave (
        input  in_valid, in_posit, out_ready,
        output in_ready, out_valid, out_sign, out_regime, out_exponent,
               out_mantissa, out_zero, out_nar
    );

    // Producer/consumer side.
    modport master (
        output in_valid, in_posit, out_ready,
        input  in_ready, out_valid, out_sign, out_regime, out_exponent,
               out_mantissa, out_zero, out_nar
    );
endinterface

// File: rtl/posit_stream_decoder.sv
// Two-stage back-pressured posit unpacker.
// S1 strips the sign (two's complement of negatives) and flags zero/NaR.
// S2 measures the regime run, pulls out the exponent and left-aligns the
// fraction under a hidden 1 at mantissa bit 7. S2 registers are the outputs.
module posit_stream_decoder #(
    parameter int WIDTH = 7,
    parameter int EN    = 1
) (
    input logic clk,
    input logic rst,
    posit_stream_decoder_if.slave bus
);
    localparam int N = WIDTH - 1;  // magnitude bits below the sign

    logic         s1_valid;
    logic         s1_sign;
    logic [N-1:0] s1_mag;
    logic         s1_zero;
    logic         s1_nar;

    logic s2_adv;
    logic s1_adv;

    logic [WIDTH-1:0] abs_posit;
    logic             in_is_zero;
    logic             in_is_nar;

    logic        r0;
    int          run;
    logic        run_done;
    logic [15:0] aligned;
    logic [15:0] shifted;
    logic [15:0] frac_bits;
    logic [7:0]  regime_val;
    logic [7:0]  exp_val;
    logic [7:0]  mant_val;

    // Stage advance: S2 moves when empty or drained, S1 when S2 can take it.
    always_comb begin
        s2_adv      = ~bus.out_valid | bus.out_ready;
        s1_adv      = ~s1_valid | s2_adv;
        bus.in_ready = s1_adv;
    end

    // Sign strip and special-value detection on the raw input.
    always_comb begin
        in_is_zero = (bus.in_posit == '0);
        in_is_nar  = (bus.in_posit == {1'b1, {(WIDTH-1){1'b0}}});
        if (bus.in_posit[WIDTH-1])
            abs_posit = (~bus.in_posit) + {{(WIDTH-1){1'b0}}, 1'b1};
        else
            abs_posit = bus.in_posit;
    end

    // Field extraction from the registered magnitude.
    always_comb begin
        r0       = s1_mag[N-1];
        run      = 1;
        run_done = 1'b0;
        for (int i = N - 2; i >= 0; i--) begin
            if (!run_done && (s1_mag[i] == r0))
                run = run + 1;
            else
                run_done = 1'b1;
        end
        aligned            = '0;
        aligned[15 -: N]   = s1_mag;
        // Drop the run and its terminator; a full-length run leaves all zeros.
        shifted    = aligned << (run + 1);
        exp_val    = 8'(shifted >> (16 - EN));
        frac_bits  = shifted << EN;
        mant_val   = {1'b1, frac_bits[15:9]};
        regime_val = r0 ? 8'(run - 1) : 8'(-run);
    end

    // S1 register: sign, magnitude and flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_mag   <= '0;
            s1_zero  <= 1'b0;
            s1_nar   <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sign <= bus.in_posit[WIDTH-1];
                s1_mag  <= abs_posit[N-1:0];
                s1_zero <= in_is_zero;
                s1_nar  <= in_is_nar;
            end
        end
    end

    // S2 register: decoded fields, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.out_valid    <= 1'b0;
            bus.out_sign     <= 1'b0;
            bus.out_regime   <= '0;
            bus.out_exponent <= '0;
            bus.out_mantissa <= '0;
            bus.out_zero     <= 1'b0;
            bus.out_nar      <= 1'b0;
        end else if (s2_adv) begin
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
                bus.out_sign <= s1_sign;
                bus.out_zero <= s1_zero;
                bus.out_nar  <= s1_nar;
                if (s1_zero || s1_nar) begin
                    bus.out_regime   <= '0;
                    bus.out_exponent <= '0;
                    bus.out_mantissa <= '0;
                end else begin
                    bus.out_regime   <= regime_val;
                    bus.out_exponent <= exp_val;
                    bus.out_mantissa <= mant_val;
                end
            end
        end
    end
endmodule

// File: tb/tb_posit_stream_decoder.sv
// Bench for posit_stream_decoder (WIDTH=7, EN=1): directed posits with
// hand-decoded fields, a back-pressure run, a full-rate run and a mid-stream reset.
module tb_posit_stream_decoder;
    localparam int W  = 7;
    localparam int EN = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    posit_stream_decoder_if #(.WIDTH(W)) bus ();
    posit_stream_decoder #(.WIDTH(W), .EN(EN)) dut (.clk(clk), .rst(rst_n), .bus(bus));

    logic [26:0] exp_q[$];
    int          cyc_q[$];
    int          checks    = 0;
    int          errors    = 0;
    int          cycle     = 0;
    int          inflight  = 0;
    bit          bp_mode   = 1'b0;
    bit          lat_check = 1'b0;
    bit          stall     = 1'b0;
    logic [26:0] held;
    logic [26:0] dut_vec;

    assign dut_vec = {bus.out_sign, bus.out_regime, bus.out_exponent,
                      bus.out_mantissa, bus.out_zero, bus.out_nar};

    always @(posedge clk) cycle++;

    function automatic logic [26:0] fields(input logic s, input int k, input int e,
                                           input logic [7:0] m, input logic z,
                                           input logic n);
        return {s, 8'(k), 8'(e), m, z, n};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Consumer ready: always on, or the 1,0,0 repeating pattern.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = bp_mode ? (cycle % 3 == 0) : 1'b1;
        end
    end

    // Monitor: in_ready model, stall stability, ordered result compare, latency.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                cyc_q.delete();
                inflight = 0;
                stall    = 1'b0;
            end else begin
                check("in_ready", 32'(bus.in_ready), 32'(!(inflight >= 2 && !bus.out_ready)));
                if (stall) begin
                    check("stall_valid", 32'(bus.out_valid), 32'd1);
                    check("stall_hold", 32'(dut_vec), 32'(held));
                end
                if (bus.out_valid) begin
                    if (bus.out_ready) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_output", 32'(dut_vec), 32'h7fff_ffff);
                        end else begin
                            check("result", 32'(dut_vec), 32'(exp_q.pop_front()));
                            if (cyc_q.size() != 0) begin
                                int acc_cyc;
                                acc_cyc = cyc_q.pop_front();
                                if (lat_check) check("latency", 32'(cycle - acc_cyc), 32'd2);
                            end
                            inflight--;
                        end
                        stall = 1'b0;
                    end else begin
                        stall = 1'b1;
                        held  = dut_vec;
                    end
                end else begin
                    stall = 1'b0;
                end
                if (bus.in_valid && bus.in_ready) begin
                    inflight++;
                    cyc_q.push_back(cycle);
                end
            end
        end
    end

    // Driver: present one posit, queue its expected fields on acceptance.
    task automatic send(input logic [W-1:0] p, input logic [26:0] e);
        bus.in_valid = 1'b1;
        bus.in_posit = p;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(e);
                @(posedge clk);
                #1;
                return;
            end
        end
        check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        bus.in_valid = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        @(negedge clk);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] vec_p[16];
    logic [26:0]  vec_e[16];

    initial begin
        // Directed decodes.
        vec_p[0]  = 7'b0101100; vec_e[0]  = fields(0,  0, 1, 8'hC0, 0, 0);
        vec_p[1]  = 7'b0110000; vec_e[1]  = fields(0,  1, 0, 8'h80, 0, 0);
        vec_p[2]  = 7'b1100000; vec_e[2]  = fields(1,  0, 0, 8'h80, 0, 0);
        vec_p[3]  = 7'b0000000; vec_e[3]  = fields(0,  0, 0, 8'h00, 1, 0);
        vec_p[4]  = 7'b1000000; vec_e[4]  = fields(1,  0, 0, 8'h00, 0, 1);
        vec_p[5]  = 7'b0111111; vec_e[5]  = fields(0,  5, 0, 8'h80, 0, 0);
        vec_p[6]  = 7'b0000001; vec_e[6]  = fields(0, -5, 0, 8'h80, 0, 0);
        vec_p[7]  = 7'b1000001; vec_e[7]  = fields(1,  5, 0, 8'h80, 0, 0);
        // Back-pressure set.
        vec_p[8]  = 7'b0101100; vec_e[8]  = fields(0,  0, 1, 8'hC0, 0, 0);
        vec_p[9]  = 7'b0110000; vec_e[9]  = fields(0,  1, 0, 8'h80, 0, 0);
        vec_p[10] = 7'b0100000; vec_e[10] = fields(0,  0, 0, 8'h80, 0, 0);
        vec_p[11] = 7'b0011000; vec_e[11] = fields(0, -1, 1, 8'h80, 0, 0);
        vec_p[12] = 7'b0100110; vec_e[12] = fields(0,  0, 0, 8'hE0, 0, 0);
        vec_p[13] = 7'b0001110; vec_e[13] = fields(0, -2, 1, 8'hC0, 0, 0);
        vec_p[14] = 7'b1010100; vec_e[14] = fields(1,  0, 1, 8'hC0, 0, 0);
        vec_p[15] = 7'b0111010; vec_e[15] = fields(0,  2, 1, 8'h80, 0, 0);

        bus.in_valid = 1'b0;
        bus.in_posit = '0;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_fields", 32'(dut_vec), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed vectors, back-to-back.
        for (int i = 0; i < 8; i++) send(vec_p[i], vec_e[i]);
        drain();

        // Back-pressure: ready toggles 1,0,0 while input stays valid.
        bp_mode = 1'b1;
        for (int i = 8; i < 16; i++) send(vec_p[i], vec_e[i]);
        drain();
        bp_mode = 1'b0;
        @(posedge clk);
        #1;

        // Full rate: every item must come out exactly 2 cycles after acceptance.
        lat_check = 1'b1;
        for (int i = 0; i < 16; i++) send(vec_p[i], vec_e[i]);
        drain();

        // Mid-stream reset: third item is on the bus when reset hits.
        send(7'b0110000, fields(0, 1, 0, 8'h80, 0, 0));
        send(7'b0101100, fields(0, 0, 1, 8'hC0, 0, 0));
        bus.in_valid = 1'b1;
        bus.in_posit = 7'b0111111;
        rst_n        = 1'b0;
        #1;
        check("midreset_out_valid", 32'(bus.out_valid), 32'd0);
        check("midreset_fields", 32'(dut_vec), 32'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(7'b0100000, fields(0, 0, 0, 8'h80, 0, 0));
        drain();
        lat_check = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
